l1_dcache_ctrl: RTL and testbench
=================================

Name: l1_dcache_ctrl

Overview:
Parametrised direct-mapped, write-back, write-allocate L1 data-cache controller for the 5-stage RISC-V pipeline MEM stage.
- Serves word loads and byte-masked stores in one cycle on a hit.
- On a miss, raises stall, writes back a dirty victim if present, then fills the line from next-level memory over a req/ack line-wide interface.
- The stall output feeds the pipeline's global cache-stall freeze.

Parameters:
ADDR_W, 32, byte address width
SETS, 64, number of lines (power of 2, ≥2)
WORDS_PER_LINE, 4, 32-bit words per line (power of 2, ≥1)
Derived (localparam): OFF_W=log2(WORDS_PER_LINE)+2; IDX_W=log2(SETS); TAG_W=ADDR_W-IDX_W-OFF_W; LINE_BITS=32*WORDS_PER_LINE

Ports:
clock  in  1  clock, rising edge
reset  in  1  asynchronous, active-low
cpu_ren  in  1  load request
cpu_wen  in  1  store request
cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored
cpu_bsel  in  4  store byte-enable, bit i -> byte i of word
cpu_wdata  in  32  store data, lane-aligned
cpu_rdata  out  32  load data, valid when cpu_ren && !cpu_stall
cpu_stall  out  1  freeze pipeline
mem_req  out  1  next-level request
mem_we  out  1  1=write-back line, 0=fill
mem_addr  out  ADDR_W  line-aligned (low OFF_W bits zero)
mem_wdata  out  LINE_BITS  victim line, word 0 in LSBs
mem_rdata  in  LINE_BITS  fill line, word 0 in LSBs
mem_ack  in  1  one-cycle pulse completing the current transfer
stat_hits  out  32  hit counter (see Optional Feature)
stat_misses  out  32  miss counter (see Optional Feature)

Behaviour:
- Address split: tag=[ADDR_W-1:IDX_W+OFF_W], index=[IDX_W+OFF_W-1:OFF_W], word=[OFF_W-1:2].
- Storage:
  - valid[SETS] and dirty[SETS] are flops cleared by reset.
  - tag and data arrays are unreset registers.
- Reset (async, reset=0): state=IDLE, all valid/dirty=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_stall=0, cpu_rdata=0, counters=0.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE:
  - hit = (ren|wen) && valid[idx] && tag match; cpu_stall=0.
  - cpu_rdata is combinational from the selected word (0-cycle latency).
  - Store hit: at the clock edge, write the enabled bytes and set dirty[idx].
  - Miss (ren|wen and !hit): cpu_stall=1 combinationally in the same cycle.
  - On a miss, the next state is WRITEBACK if valid&&dirty, else ALLOCATE.
- WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag,idx,0}, mem_wdata=victim line. On mem_ack: clear dirty[idx] and go to ALLOCATE.
- ALLOCATE: mem_req=1, mem_we=0, mem_addr={req tag,idx,0}. On mem_ack: write the whole line, tag, valid=1, dirty=0, then go to IDLE.
- Replay: after a fill, IDLE re-evaluates the held request, which now hits.
  - Miss penalty = memory latency + 1 cycle (no writeback).
  - With a writeback, add a second memory transaction.
- cpu_stall=1 in every WRITEBACK/ALLOCATE cycle, including the mem_ack cycle.
- mem_req, mem_we, mem_addr and mem_wdata stay stable from request until mem_ack.
- mem_ack outside WRITEBACK/ALLOCATE is ignored.
- Memory never acks in the same cycle mem_req first rises.
- Pipeline holds cpu_* stable while cpu_stall=1.
- cpu_ren && cpu_wen together: treated as a store.
- cpu_bsel=0 on a store: hit still completes, data unchanged, dirty set.
- Reset asserted mid-transfer: immediate return to IDLE, mem_req drops asynchronously, the in-flight fill is discarded, and the line stays invalid.
- No requests (ren=wen=0): no state change, stall=0.

Optional Feature:
Macro DCACHE_STATS_EN.
- Defined: stat_hits increments on each IDLE cycle with hit; stat_misses increments once per miss (on the IDLE→WRITEBACK/ALLOCATE transition). Both counters are 32-bit and wrap at 2^32.
- Undefined: counter flops are not built; stat_hits and stat_misses are tied to 0. Ports are always present.

Decomposition:
- Shared package/header (dcache_pkg): FSM state encodings (IDLE=2'd0, WRITEBACK=2'd1, ALLOCATE=2'd2), default SETS/WORDS_PER_LINE, the log2 helper function.
- One natural sub-module: dcache_line_merge. It is combinational: it applies cpu_bsel/cpu_wdata into the addressed word of a line and extracts the read word.

Test Plan (SETS=64, WORDS_PER_LINE=4; index=addr[9:4]):
1. Cold read 0x100 → stall=1 same cycle; mem_req=1, mem_we=0, mem_addr=0x100. Ack 2 cycles later with line {0x44444444,0x33333333,0x22222222,0x11111111} → next cycle stall=0, cpu_rdata=0x11111111.
2. Read 0x104 after test 1 → stall stays 0, cpu_rdata=0x22222222 same cycle, no mem_req.
3. Store 0x100 with bsel=4'b0100, wdata=0x00AB0000 → no stall; then read 0x100 → 0x11AB1111.
4. Read 0x500 (index 0x10, new tag) after test 3 → WRITEBACK: mem_we=1, mem_addr=0x100, mem_wdata word0=0x11AB1111. Then ack → ALLOCATE, mem_addr=0x500. Then ack → stall=0.
5. Assert reset during ALLOCATE for 0x100 → mem_req=0 immediately. After release, read 0x100 misses again (mem_req=1, mem_addr=0x100).
6. With DCACHE_STATS_EN, run tests 1-3 → stat_hits=3 (test 2 read, test 3 store, test 3 read), stat_misses=1. Without the macro, both counters read 0.

Source files
------------

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types, defaults and helpers for the L1 data-cache controller
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  localparam int DEFAULT_SETS           = 64;
  localparam int DEFAULT_WORDS_PER_LINE = 4;

  // floor(log2(value)); geometry parameters are powers of two so this is exact
  function automatic int log2_int(input int value);
    int result;
    result = 0;
    for (int v = value; v > 1; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dcache_line_merge.sv
// rtl/dcache_line_merge.sv - merges a byte-masked store into a cache line and extracts the addressed word
module dcache_line_merge
  import dcache_pkg::*;
#(
  parameter int WORDS_PER_LINE = DEFAULT_WORDS_PER_LINE,
  parameter int WSEL_W         = 2
) (
  input  logic [32*WORDS_PER_LINE-1:0] line,
  input  logic [WSEL_W-1:0]            word_sel,
  input  logic [3:0]                   bsel,
  input  logic [31:0]                  wdata,
  output logic [32*WORDS_PER_LINE-1:0] merged,
  output logic [31:0]                  rdata
);

  // read the selected word and overlay the enabled store bytes onto it
  always_comb begin
    merged = line;
    rdata  = line[int'(word_sel)*32 +: 32];
    for (int b = 0; b < 4; b++) begin
      if (bsel[b]) begin
        merged[int'(word_sel)*32 + b*8 +: 8] = wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/l1_dcache_ctrl.sv
// rtl/l1_dcache_ctrl.sv - direct-mapped write-back write-allocate L1 D-cache controller; hit/miss counters built only with DCACHE_STATS_EN
module l1_dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int SETS           = DEFAULT_SETS,
  parameter int WORDS_PER_LINE = DEFAULT_WORDS_PER_LINE
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cpu_ren,
  input  logic                         cpu_wen,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [3:0]                   cpu_bsel,
  input  logic [31:0]                  cpu_wdata,
  output logic [31:0]                  cpu_rdata,
  output logic                         cpu_stall,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [32*WORDS_PER_LINE-1:0] mem_wdata,
  input  logic [32*WORDS_PER_LINE-1:0] mem_rdata,
  input  logic                         mem_ack,
  output logic [31:0]                  stat_hits,
  output logic [31:0]                  stat_misses
);

  localparam int WSEL_BITS = log2_int(WORDS_PER_LINE);
  localparam int OFF_W     = WSEL_BITS + 2;
  localparam int IDX_W     = log2_int(SETS);
  localparam int TAG_W     = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_BITS = 32 * WORDS_PER_LINE;
  localparam int WSEL_W    = (WSEL_BITS > 0) ? WSEL_BITS : 1;

  state_t               state;
  logic [SETS-1:0]      valid_q;
  logic [SETS-1:0]      dirty_q;
  logic [TAG_W-1:0]     tag_mem  [SETS];
  logic [LINE_BITS-1:0] data_mem [SETS];

  logic [TAG_W-1:0]     req_tag;
  logic [IDX_W-1:0]     idx;
  logic [WSEL_W-1:0]    word_sel;
  logic                 cpu_req;
  logic                 in_idle;
  logic                 hit;
  logic                 miss;
  logic                 store_hit;
  logic                 fill_done;
  logic [LINE_BITS-1:0] merged_line;
  logic [31:0]          read_word;
  logic                 unused_addr_bits;

  assign req_tag          = cpu_addr[ADDR_W-1:IDX_W+OFF_W];
  assign idx              = cpu_addr[IDX_W+OFF_W-1:OFF_W];
  assign unused_addr_bits = ^cpu_addr[1:0];

  generate
    if (WSEL_BITS > 0) begin : g_word_sel
      assign word_sel = cpu_addr[OFF_W-1:2];
    end else begin : g_single_word
      assign word_sel = 1'b0;
    end
  endgenerate

  // a simultaneous load and store is handled as a store
  assign cpu_req   = cpu_ren | cpu_wen;
  assign in_idle   = (state == IDLE);
  assign hit       = in_idle && cpu_req && valid_q[idx] && (tag_mem[idx] == req_tag);
  assign miss      = in_idle && cpu_req && !hit;
  assign store_hit = hit && cpu_wen;
  assign fill_done = (state == ALLOCATE) && mem_ack;

  // stall is combinational so a miss freezes the pipeline in the cycle it is detected
  assign cpu_stall = reset & (!in_idle | miss);
  assign cpu_rdata = hit ? read_word : 32'd0;

  dcache_line_merge #(
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .WSEL_W         (WSEL_W)
  ) u_merge (
    .line     (data_mem[idx]),
    .word_sel (word_sel),
    .bsel     (cpu_bsel),
    .wdata    (cpu_wdata),
    .merged   (merged_line),
    .rdata    (read_word)
  );

  // tag/data storage: a fill replaces the whole line, a store hit merges bytes
  always_ff @(posedge clock) begin
    if (fill_done) begin
      data_mem[idx] <= mem_rdata;
      tag_mem[idx]  <= req_tag;
    end else if (store_hit) begin
      data_mem[idx] <= merged_line;
    end
  end

  // miss FSM with registered memory-side outputs; reset abandons any transfer in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      valid_q   <= '0;
      dirty_q   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (store_hit) begin
            dirty_q[idx] <= 1'b1;
          end else if (miss) begin
            mem_req <= 1'b1;
            if (valid_q[idx] && dirty_q[idx]) begin
              state     <= WRITEBACK;
              mem_we    <= 1'b1;
              mem_addr  <= {tag_mem[idx], idx, {OFF_W{1'b0}}};
              mem_wdata <= data_mem[idx];
            end else begin
              state    <= ALLOCATE;
              mem_we   <= 1'b0;
              mem_addr <= {req_tag, idx, {OFF_W{1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack) begin
            dirty_q[idx] <= 1'b0;
            state        <= ALLOCATE;
            mem_we       <= 1'b0;
            mem_addr     <= {req_tag, idx, {OFF_W{1'b0}}};
          end
        end
        ALLOCATE: begin
          if (mem_ack) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
            state        <= IDLE;
            mem_req      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hits_q;
  logic [31:0] misses_q;
  logic        replay_q;

  // count fresh hits and misses; the replay cycle after a fill belongs to its miss, not a new hit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hits_q   <= 32'd0;
      misses_q <= 32'd0;
      replay_q <= 1'b0;
    end else begin
      replay_q <= fill_done;
      if (hit && !replay_q) begin
        hits_q <= hits_q + 32'd1;
      end
      if (miss) begin
        misses_q <= misses_q + 32'd1;
      end
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`else
  assign stat_hits   = 32'd0;
  assign stat_misses = 32'd0;
`endif

endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// tb/tb_l1_dcache_ctrl.sv - self-checking bench for l1_dcache_ctrl against a flat-memory cache model
module tb_l1_dcache_ctrl;

`ifdef DCACHE_STATS_EN
  localparam int STATS_ON = 1;
`else
  localparam int STATS_ON = 0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         cpu_ren = 1'b0;
  logic         cpu_wen = 1'b0;
  logic [31:0]  cpu_addr = 32'd0;
  logic [3:0]   cpu_bsel = 4'd0;
  logic [31:0]  cpu_wdata = 32'd0;
  logic [31:0]  cpu_rdata;
  logic         cpu_stall;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ack = 1'b0;
  logic [31:0]  stat_hits;
  logic [31:0]  stat_misses;

  int tests_run = 0;
  int tests_failed = 0;

  l1_dcache_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .cpu_ren     (cpu_ren),
    .cpu_wen     (cpu_wen),
    .cpu_addr    (cpu_addr),
    .cpu_bsel    (cpu_bsel),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_stall   (cpu_stall),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
  );

  always #5 clock = ~clock;

  // model: next-level memory plus which line each set holds and its current contents
  logic [127:0] backing [logic [31:0]];
  bit           res_valid [64];
  bit           res_dirty [64];
  logic [31:0]  res_line  [64];
  logic [127:0] res_data  [64];
  int           hits_exp = 0;
  int           misses_exp = 0;
  logic [31:0]  last_wb_addr = '0;
  logic [127:0] last_wb_data = '0;
  logic [31:0]  last_fill_addr = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] back_line(input logic [31:0] la);
    logic [127:0] l;
    if (backing.exists(la)) return backing[la];
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = (la + 32'(4*w)) ^ 32'hC0DE_0000;
    return l;
  endfunction

  function automatic logic [31:0] view_word(input logic [31:0] a);
    logic [31:0]  la;
    logic [127:0] l;
    int           ix;
    la = {a[31:4], 4'h0};
    ix = int'(a[9:4]);
    l = (res_valid[ix] && res_line[ix] == la) ? res_data[ix] : back_line(la);
    return l[int'(a[3:2])*32 +: 32];
  endfunction

  task automatic apply_store(input logic [31:0] a, input logic [3:0] bs, input logic [31:0] wd);
    logic [127:0] l;
    int           ix;
    ix = int'(a[9:4]);
    l = res_data[ix];
    for (int b = 0; b < 4; b++)
      if (bs[b]) l[int'(a[3:2])*32 + b*8 +: 8] = wd[b*8 +: 8];
    res_data[ix]  = l;
    res_dirty[ix] = 1'b1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) begin
      res_valid[i] = 1'b0;
      res_dirty[i] = 1'b0;
    end
    hits_exp = 0;
    misses_exp = 0;
  endtask

  // next-level memory responder for one transfer; acks after lat extra cycles
  task automatic serve(input bit we, input logic [31:0] la, input int lat);
    int n;
    n = 0;
    @(negedge clock);
    while (!mem_req && n < 10) begin
      @(negedge clock);
      n++;
    end
    check("mem_req_rise", mem_req, 1'b1);
    if (!mem_req) return;
    check(we ? "wb_we" : "fill_we", mem_we, we);
    check(we ? "wb_addr" : "fill_addr", mem_addr, la);
    if (we) begin
      check("wb_data", mem_wdata, res_data[int'(la[9:4])]);
      last_wb_addr = mem_addr;
      last_wb_data = mem_wdata;
    end else begin
      last_fill_addr = mem_addr;
    end
    repeat (lat) @(negedge clock);
    check("req_held", {mem_req, mem_we, mem_addr}, {1'b1, we, la});
    mem_rdata = we ? '0 : back_line(la);
    mem_ack = 1'b1;
    @(posedge clock);
    #1 mem_ack = 1'b0;
  endtask

  // one CPU access held until it completes; returns at the negedge of its final cycle
  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [3:0] bs, input logic [31:0] wd);
    logic [31:0] la;
    int          ix;
    bit          hit_exp;
    la = {a[31:4], 4'h0};
    ix = int'(a[9:4]);
    @(posedge clock);
    #1;
    cpu_ren = rd;
    cpu_wen = wr;
    cpu_addr = a;
    cpu_bsel = bs;
    cpu_wdata = wd;
    hit_exp = res_valid[ix] && (res_line[ix] == la);
    @(negedge clock);
    check("first_cycle_stall", cpu_stall, !hit_exp);
    if (hit_exp) begin
      hits_exp++;
    end else begin
      misses_exp++;
      if (res_valid[ix] && res_dirty[ix]) begin
        serve(1'b1, res_line[ix], 1);
        backing[res_line[ix]] = res_data[ix];
        res_dirty[ix] = 1'b0;
      end
      serve(1'b0, la, 1);
      res_valid[ix] = 1'b1;
      res_line[ix]  = la;
      res_data[ix]  = back_line(la);
      res_dirty[ix] = 1'b0;
      @(negedge clock);
      check("replay_stall", cpu_stall, 1'b0);
    end
    if (wr) apply_store(a, bs, wd);
  endtask

  task automatic idle_cycles(input int n);
    @(posedge clock);
    #1;
    cpu_ren = 1'b0;
    cpu_wen = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  // every cycle: completed loads must return the model's memory value; transfers must stall
  always @(negedge clock) begin
    if (reset) begin
      if (cpu_ren && !cpu_wen && !cpu_stall) check("load_data", cpu_rdata, view_word(cpu_addr));
      if (mem_req) check("stall_during_mem", cpu_stall, 1'b1);
      if (!cpu_ren && !cpu_wen) check("idle_no_stall", cpu_stall, 1'b0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    backing[32'h100] = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

    // reset state
    repeat (3) @(negedge clock);
    check("rst_stall", cpu_stall, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 128'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_hits", stat_hits, 32'd0);
    check("rst_misses", stat_misses, 32'd0);
    reset = 1'b1;
    idle_cycles(2);

    // cold read miss and fill
    access(1'b1, 1'b0, 32'h100, 4'h0, 32'h0);
    check("t1_fill_addr", last_fill_addr, 32'h100);
    check("t1_rdata", cpu_rdata, 32'h11111111);

    // read hit in the same line
    access(1'b1, 1'b0, 32'h104, 4'h0, 32'h0);
    check("t2_rdata", cpu_rdata, 32'h22222222);
    check("t2_no_req", mem_req, 1'b0);

    // byte store hit then read back
    access(1'b0, 1'b1, 32'h100, 4'b0100, 32'h00AB0000);
    access(1'b1, 1'b0, 32'h100, 4'h0, 32'h0);
    check("t3_rdata", cpu_rdata, 32'h11AB1111);
    check("t3_hits", stat_hits, 32'(3 * STATS_ON));
    check("t3_misses", stat_misses, 32'(1 * STATS_ON));

    // conflict miss with dirty victim
    access(1'b1, 1'b0, 32'h500, 4'h0, 32'h0);
    check("t4_wb_addr", last_wb_addr, 32'h100);
    check("t4_wb_word0", last_wb_data[31:0], 32'h11AB1111);
    check("t4_fill_addr", last_fill_addr, 32'h500);

    // stray ack while idle must be ignored
    idle_cycles(1);
    mem_ack = 1'b1;
    @(posedge clock);
    #1 mem_ack = 1'b0;
    @(negedge clock);
    check("stray_ack_req", mem_req, 1'b0);
    check("stray_ack_stall", cpu_stall, 1'b0);

    // ren+wen store with bsel=0 still dirties the line; eviction writes it back unchanged
    access(1'b1, 1'b1, 32'h504, 4'h0, 32'hFFFFFFFF);
    access(1'b1, 1'b0, 32'h904, 4'h0, 32'h0);
    check("bsel0_wb_addr", last_wb_addr, 32'h500);
    access(1'b1, 1'b1, 32'h908, 4'hF, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h908, 4'h0, 32'h0);
    check("both_store_rdata", cpu_rdata, 32'hDEADBEEF);

    // last set and maximum tag
    access(1'b1, 1'b0, 32'h3F0, 4'h0, 32'h0);
    access(1'b0, 1'b1, 32'h3FC, 4'b1001, 32'h12345678);
    access(1'b1, 1'b0, 32'hFFFFFFF0, 4'h0, 32'h0);
    check("set63_wb_addr", last_wb_addr, 32'h3F0);
    access(1'b1, 1'b0, 32'hFFFFFFFC, 4'h0, 32'h0);
    check("maxtag_rdata", cpu_rdata, 32'h3F21FFFC);
    access(1'b1, 1'b0, 32'h3FC, 4'h0, 32'h0);
    check("set63_merged", cpu_rdata, 32'h12DE0378);
    check("mid_hits", stat_hits, 32'(hits_exp * STATS_ON));
    check("mid_misses", stat_misses, 32'(misses_exp * STATS_ON));

    // reset during ALLOCATE (victim 0x900 line is dirty, so a writeback comes first)
    @(posedge clock);
    #1;
    cpu_ren = 1'b1;
    cpu_wen = 1'b0;
    cpu_addr = 32'h100;
    @(negedge clock);
    check("t5_miss_stall", cpu_stall, 1'b1);
    if (res_valid[16] && res_dirty[16]) begin
      serve(1'b1, res_line[16], 1);
      backing[res_line[16]] = res_data[16];
      res_dirty[16] = 1'b0;
    end
    @(negedge clock);
    check("t5_alloc", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h100});
    #2 reset = 1'b0;
    #1;
    check("t5_req_drop", mem_req, 1'b0);
    check("t5_addr_clr", mem_addr, 32'd0);
    cpu_ren = 1'b0;
    clear_model();
    @(negedge clock);
    check("t5_rst_stall", cpu_stall, 1'b0);
    check("t5_rst_hits", stat_hits, 32'd0);
    check("t5_rst_misses", stat_misses, 32'd0);
    reset = 1'b1;
    access(1'b1, 1'b0, 32'h100, 4'h0, 32'h0);
    check("t5_refill_addr", last_fill_addr, 32'h100);
    check("t5_rdata", cpu_rdata, 32'h11AB1111);
    access(1'b1, 1'b0, 32'h10C, 4'h0, 32'h0);
    check("t5_hit_rdata", cpu_rdata, 32'h44444444);

    idle_cycles(2);
    check("end_hits", stat_hits, 32'(hits_exp * STATS_ON));
    check("end_misses", stat_misses, 32'(misses_exp * STATS_ON));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
